// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, active-low
// hex glyph table (seg[6:0] = g..a) and the all-off pin levels.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] ALL_OFF_SEG = 7'h7F;
    localparam logic [7:0] ALL_OFF_AN  = 8'hFF;

    // Index 0 is the rightmost entry; b and d are lowercase glyphs.
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Processor-side word and display controls in, display pins and update strobe out.
// master = upstream/processor side, slave = the scan driver.
interface seg7_scan_driver_if;
    logic [31:0] value;
    logic        blank_lz;
    logic [2:0]  bright;
    logic        freeze;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        upd;

    modport master (
        output value, blank_lz, bright, freeze,
        input  an, seg, upd
    );

    modport slave (
        input  value, blank_lz, bright, freeze,
        output an, seg, upd
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Zero latency, no flow control.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPHS[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display driver with stability filter, PWM and
// leading-zero blanking; an/seg/upd registered one cycle after scan state, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int THR_W = (CNT_W + 4 > 23) ? CNT_W + 4 : 23;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [THR_W-1:0] DC_EXT   = THR_W'(DIGIT_CYCLES);

    logic [31:0]      smp_q, smp_d;
    logic [31:0]      shown_q, shown_d;
    logic             upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic [THR_W-1:0]      thr;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  blank;
    logic                  lit;

    // A word must match on two consecutive edges before it is shown.
    always_comb begin
        smp_d   = bus.value;
        shown_d = shown_q;
        upd_d   = 1'b0;
        if ((bus.value == smp_q) && !bus.freeze && (bus.value != shown_q)) begin
            shown_d = bus.value;
            upd_d   = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    assign thr = ((THR_W'(bus.bright) + THR_W'(1)) * DC_EXT) >> 3;
    assign nib = shown_q[4*idx_q +: 4];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    // zero_from[i] is set when nibbles i..7 are all zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (shown_q[31:28] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shown_q[4*i +: 4] == 4'h0);
        end
    end

    assign blank = bus.blank_lz && (idx_q != 3'd0) && zero_from[idx_q];
    // cnt == 0 stays dark so the anode switch never overlaps the old glyph.
    assign lit   = (cnt_q != '0) && (THR_W'(cnt_q) < thr) && !blank;

    always_comb begin
        an_d  = ALL_OFF_AN;
        seg_d = ALL_OFF_SEG;
        if (lit) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q   <= '0;
            shown_q <= '0;
            upd_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= ALL_OFF_AN;
            seg_q   <= ALL_OFF_SEG;
        end else begin
            smp_q   <= smp_d;
            shown_q <= shown_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.upd = upd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIGIT_CYCLES=16: reset, capture,
// decode, PWM, blanking, glitch rejection and freeze.
module tb_seg7_scan_driver;

    localparam int DC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.DIGIT_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scan position tracker: m_* is the counter state, o_* the state the
    // registered outputs currently reflect.
    logic [3:0] m_cnt, o_cnt;
    logic [2:0] m_idx, o_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0; m_idx <= '0; o_cnt <= '0; o_idx <= '0;
        end else begin
            o_cnt <= m_cnt;
            o_idx <= m_idx;
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd15) m_idx <= m_idx + 3'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [2:0] idx, input logic [3:0] cnt);
        int n = 0;
        while (!(o_idx == idx && o_cnt == cnt) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            tests++; fails++;
            $display("FAIL goto_timeout: slot %0d cnt %0d not reached", idx, cnt);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        bus.value = 32'h0; bus.bright = 3'd7; bus.blank_lz = 1'b0; bus.freeze = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        while (!(m_cnt == 4'd5 && m_idx == 3'd3) && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (bus.an !== 8'hF7) begin
            fails++; $display("FAIL rst_pre_an: got %h expected %h", bus.an, 8'hF7);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.an !== 8'hFF) begin
            fails++; $display("FAIL rst_async_an: got %h expected %h", bus.an, 8'hFF);
        end
        tests++;
        if (bus.seg !== 7'h7F) begin
            fails++; $display("FAIL rst_async_seg: got %h expected %h", bus.seg, 7'h7F);
        end
        tests++;
        if (bus.upd !== 1'b0) begin
            fails++; $display("FAIL rst_async_upd: got %b expected 0", bus.upd);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8 * DC + 1; i++) begin
            logic [7:0] ea;
            logic [6:0] es;
            step();
            ea = (o_cnt == 4'd0) ? 8'hFF : ~(8'b1 << o_idx);
            es = (o_cnt == 4'd0) ? 7'h7F : 7'h40;
            tests++;
            if (bus.an !== ea || bus.seg !== es) begin
                fails++;
                $display("FAIL rst_scan slot %0d cnt %0d: got an=%h seg=%h expected an=%h seg=%h",
                         o_idx, o_cnt, bus.an, bus.seg, ea, es);
            end
        end
    endtask

    task automatic test_capture();
        int pulses = 0;
        bus.value = 32'h1234ABCD;
        step();
        tests++;
        if (bus.upd !== 1'b0) begin
            fails++; $display("FAIL cap_upd_edge1: got %b expected 0", bus.upd);
        end
        step();
        tests++;
        if (bus.upd !== 1'b1) begin
            fails++; $display("FAIL cap_upd_edge2: got %b expected 1", bus.upd);
        end
        step();
        tests++;
        if (bus.upd !== 1'b0) begin
            fails++; $display("FAIL cap_upd_edge3: got %b expected 0", bus.upd);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.upd === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL cap_extra_upd: got %0d pulses expected 0", pulses);
        end
        goto(3'd0, 4'd1);
        tests++;
        if (bus.an !== 8'hFE || bus.seg !== 7'h21) begin
            fails++; $display("FAIL cap_slot0: got an=%h seg=%h expected an=fe seg=21", bus.an, bus.seg);
        end
        goto(3'd4, 4'd8);
        tests++;
        if (bus.an !== 8'hEF || bus.seg !== 7'h19) begin
            fails++; $display("FAIL cap_slot4: got an=%h seg=%h expected an=ef seg=19", bus.an, bus.seg);
        end
        goto(3'd7, 4'd5);
        tests++;
        if (bus.an !== 8'h7F || bus.seg !== 7'h79) begin
            fails++; $display("FAIL cap_slot7: got an=%h seg=%h expected an=7f seg=79", bus.an, bus.seg);
        end
    endtask

    task automatic test_brightness();
        logic [2:0] br    [3] = '{3'd3, 3'd0, 3'd7};
        int         thr   [3] = '{8, 2, 16};
        int         e_lit [3] = '{7, 1, 15};
        for (int k = 0; k < 3; k++) begin
            int nlit = 0;
            bus.bright = br[k];
            goto(3'(k + 1), 4'd0);
            for (int c = 0; c < 16; c++) begin
                logic exp_lit;
                logic obs_lit;
                if (c > 0) step();
                exp_lit = (c >= 1) && (c < thr[k]);
                obs_lit = (bus.an !== 8'hFF);
                if (obs_lit) nlit++;
                tests++;
                if (obs_lit !== exp_lit) begin
                    fails++;
                    $display("FAIL bright%0d_cnt%0d: got lit=%b expected lit=%b", br[k], c, obs_lit, exp_lit);
                end
            end
            tests++;
            if (nlit != e_lit[k]) begin
                fails++; $display("FAIL bright%0d_count: got %0d lit cycles expected %0d", br[k], nlit, e_lit[k]);
            end
        end
        bus.bright = 3'd7;
    endtask

    task automatic test_blanking();
        logic [7:0] ea0 [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [6:0] es0 [8] = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic [7:0] ea1 [8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [6:0] es1 [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        bus.blank_lz = 1'b1;
        bus.value = 32'h000000A0;
        repeat (3) step();
        for (int s = 0; s < 8; s++) begin
            goto(3'(s), 4'd3);
            tests++;
            if (bus.an !== ea0[s] || bus.seg !== es0[s]) begin
                fails++;
                $display("FAIL blank_a0_slot%0d: got an=%h seg=%h expected an=%h seg=%h",
                         s, bus.an, bus.seg, ea0[s], es0[s]);
            end
        end
        bus.value = 32'h0;
        repeat (3) step();
        for (int s = 0; s < 8; s++) begin
            goto(3'(s), 4'd3);
            tests++;
            if (bus.an !== ea1[s] || bus.seg !== es1[s]) begin
                fails++;
                $display("FAIL blank_zero_slot%0d: got an=%h seg=%h expected an=%h seg=%h",
                         s, bus.an, bus.seg, ea1[s], es1[s]);
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        bus.value = 32'h00000077;
        repeat (3) step();
        bus.value = 32'h00000005;
        step();
        bus.value = 32'h00000077;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.upd === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL glitch_upd: got %0d pulses expected 0", pulses);
        end
        goto(3'd0, 4'd3);
        tests++;
        if (bus.seg !== 7'h78) begin
            fails++; $display("FAIL glitch_slot0: got seg=%h expected 78", bus.seg);
        end
        goto(3'd2, 4'd3);
        tests++;
        if (bus.seg !== 7'h40) begin
            fails++; $display("FAIL glitch_slot2: got seg=%h expected 40", bus.seg);
        end
    endtask

    task automatic test_freeze();
        int pulses = 0;
        bus.freeze = 1'b1;
        bus.value = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.upd === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL freeze_upd: got %0d pulses expected 0", pulses);
        end
        goto(3'd0, 4'd2);
        tests++;
        if (bus.an !== 8'hFE || bus.seg !== 7'h78) begin
            fails++; $display("FAIL freeze_hold: got an=%h seg=%h expected an=fe seg=78", bus.an, bus.seg);
        end
        bus.freeze = 1'b0;
        step();
        tests++;
        if (bus.upd !== 1'b1 || bus.seg !== 7'h78) begin
            fails++; $display("FAIL unfreeze_edge1: got upd=%b seg=%h expected upd=1 seg=78", bus.upd, bus.seg);
        end
        step();
        tests++;
        if (bus.upd !== 1'b0 || bus.an !== 8'hFE || bus.seg !== 7'h0E) begin
            fails++;
            $display("FAIL unfreeze_edge2: got upd=%b an=%h seg=%h expected upd=0 an=fe seg=0e",
                     bus.upd, bus.an, bus.seg);
        end
        goto(3'd3, 4'd5);
        tests++;
        if (bus.an !== 8'hF7 || bus.seg !== 7'h03) begin
            fails++; $display("FAIL unfreeze_slot3: got an=%h seg=%h expected an=f7 seg=03", bus.an, bus.seg);
        end
        goto(3'd7, 4'd5);
        tests++;
        if (bus.an !== 8'h7F || bus.seg !== 7'h21) begin
            fails++; $display("FAIL unfreeze_slot7: got an=%h seg=%h expected an=7f seg=21", bus.an, bus.seg);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_brightness();
        test_blanking();
        test_glitch();
        test_freeze();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Board-level output stage that consumes the processor's 32-bit memory-mapped output word and shows it as eight hexadecimal digits on a multiplexed, common-anode seven-segment display. It filters the incoming word so only stable values are shown, scans the digits with a programmable per-digit dwell, and applies PWM brightness control. It can also blank leading zeros. It sits directly downstream of the processor top level, on the undivided board clock, and drives the FPGA anode and cathode pins.

## Interface
- DIGIT_CYCLES, 100000, clock cycles per digit slot, legal range ≥ 8.
- clk  in  1  board clock. All state updates on its rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- value  in  32  word to display, the processor output port. It is quasi-static relative to clk.
- blank_lz  in  1  1 = blank leading zero digits.
- bright  in  3  on-time in eighths of a slot, minus one.
- freeze  in  1  1 = hold the currently shown word.
- an  out  8  anodes, active-low. an[i] selects digit i, and digit 0 is the rightmost.
- seg  out  7  cathodes, active-low, with seg[0]=a through seg[6]=g.
- upd  out  1  single-cycle pulse when the shown word changes.

## Operation
- **Capture.** Every cycle `smp <= value`.
  - If `value == smp`, `freeze == 0` and `value != shown`, then `shown <= value` and `upd <= 1`.
  - Otherwise `upd <= 0`.
  - A value present for only one edge is never shown.
- **Scan.** `cnt` counts 0 to DIGIT_CYCLES-1.
  - When `cnt` wraps to 0, `idx` (3 bits) increments, wrapping from 7 to 0.
  - The nibble for slot `idx` is `shown[4*idx+3 : 4*idx]`.
- **Decode.** The hex glyphs 0–F use the standard patterns: b and d are lowercase, the rest uppercase.
- **Brightness.**
  - `thr = ((bright+1) * DIGIT_CYCLES) >> 3`, with integer floor. Compute it at ≥ 20+3 bits wide with no truncation.
  - The digit is lit when `1 ≤ cnt < thr`.
  - `cnt == 0` is always dark. This guard cycle prevents ghosting across slot changes.
- **Leading-zero blanking.**
  - Digit `idx` is blank when `blank_lz == 1`, `idx != 0`, and every nibble from `idx` to 7 is zero.
  - Digit 0 is never blanked.
- **Outputs while lit:** `an = ~(1 << idx)` and `seg = glyph`.
- **Outputs while dark or blank:** `an = 8'hFF` and `seg = 7'h7F`.
- **Reset values:** `smp=0`, `shown=0`, `cnt=0`, `idx=0`, `an=8'hFF`, `seg=7'h7F`, `upd=0`. These apply immediately on rst assertion, regardless of scan position.

## Timing
- `an`, `seg` and `upd` are registered.
  - `an` and `seg` in cycle t+1 are a function of `cnt`, `idx`, `shown`, `bright` and `blank_lz` in cycle t.
  - `an` and `seg` always change on the same edge.
- **Value latency.** Suppose `value` changes before edge k and is held. Then `smp` updates at edge k, and `shown` and `upd=1` update at edge k+1. `upd` returns to 0 at edge k+2 unless another change qualifies.
- **Freeze.**
  - While `freeze=1`, `shown` holds even if `value` is stable and different.
  - If `value` is already stable when `freeze` falls, `shown` updates on the first edge with `freeze=0`.
- **Mid-slot changes.**
  - A `bright` change takes effect on the next cycle's comparison.
  - A `blank_lz` change takes effect on the next cycle's output.
  - A `shown` change mid-slot changes `seg` on the following cycle. The scan does not restart.
- The full refresh period is 8·DIGIT_CYCLES cycles.

## Structure
- **Shared package `seg7_pkg`:**
  - NUM_DIGITS = 8.
  - The 16-entry active-low glyph constant table, in seg[6:0] = g..a order.
  - Named constants for the segment bit positions, ALL_OFF_SEG = 7'h7F and ALL_OFF_AN = 8'hFF.
- **Sub-module `seg7_hex_decode`:** combinational, 4-bit nibble in and 7-bit active-low seg out, indexing the package table.
- Capture, scan counters, blanking and PWM stay in the top module.

## Test plan
All scenarios use DIGIT_CYCLES=16.
1. **Reset.** Assert rst mid-slot at cnt=5, idx=3 → `an=8'hFF`, `seg=7'h7F`, `upd=0` with no clock edge needed. After release with value=0, bright=7, blank_lz=0 → every slot shows `seg=7'h40` ('0') for cnt 1..15 and is dark at cnt 0.
2. **Capture and decode.** value=32'h1234ABCD held, bright=7 → exactly one `upd` pulse, two edges after the change.
   - Slot 0: `an=8'hFE`, `seg=7'h21` ('d').
   - Slot 7: `an=8'h7F`, `seg=7'h79` ('1').
3. **Brightness.**
   - bright=3 → thr=8, lit for cnt 1..7, which is 7 of 16 cycles.
   - bright=0 → thr=2, lit for 1 cycle.
   - bright=7 → lit for 15 cycles.
4. **Blanking.**
   - blank_lz=1, value=32'h000000A0 → slots 2..7 give `an=8'hFF`. Slot 1 shows 'A' (`7'h08`) and slot 0 shows '0'.
   - value=0 → only digit 0 is lit.
5. **Glitch rejection.** value=32'h00000005 for one cycle, then back to the prior value → no `upd` and `shown` is unchanged.
6. **Freeze.** Set freeze=1, then value=32'hDEADBEEF held 10 cycles → no `upd` and the display is unchanged. Drop freeze → `upd` on the first edge with freeze=0 and the new digits appear from the next cycle.
